mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Memory-side initiator that drives the word-addressed data memory port (ren, wen, addr, din) and samples its dout.
- Copies a block of LEN words from SRC to DST with memmove semantics, so overlapping ranges are handled correctly.
- Sits beside the pipeline as a software-triggered copy engine, muxed onto the data memory port while busy.
- Never asserts ren and wen together; each word takes one read cycle followed by one write cycle.

Parameters:
- AW, 10: valid word-address width. Addresses must satisfy addr[31:AW] == 0.
- LW, 11: length field width. Allows 0..1024 words.

Ports:
- clock  input  1  system clock, posedge-sampled.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- src  input  32  source word address.
- dst  input  32  destination word address.
- len  input  LW  word count.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse, high in DONE.
- err  output  1  one-cycle pulse when a request is rejected.
- mem_ren  output  1  memory read enable.
- mem_wen  output  1  memory write enable.
- mem_addr  output  32  memory word address.
- mem_din  output  32  write data to memory.
- mem_dout  input  32  read data from memory (combinational when ren=1 and wen=0).

Behaviour:
- Reset (sampled at posedge with reset=1):
  - state=IDLE.
  - busy, done, err, mem_ren, mem_wen = 0.
  - mem_addr = 0, mem_din = 0.
  - Reset mid-transfer aborts immediately; partially copied words remain; no done pulse.
- FSM states: IDLE, READ, WRITE, DONE. All outputs are Moore, decoded from registered state and datapath registers.
- IDLE, start=1:
  - Range check: if len != 0 and (src+len-1 or dst+len-1 >= 2^AW, or any upper bits are set), pulse err for the next cycle and stay IDLE. No memory access.
  - If len == 0: go to DONE.
  - Otherwise latch the count and pick direction: descending if dst > src and dst < src+len, else ascending.
  - Ascending: cur_src=src, cur_dst=dst. Descending: cur_src=src+len-1, cur_dst=dst+len-1. Then go to READ.
  - start in any other state is ignored.
- READ: mem_ren=1, mem_wen=0, mem_addr=cur_src. At posedge, capture mem_dout into data_q and go to WRITE.
- WRITE: mem_wen=1, mem_ren=0, mem_addr=cur_dst, mem_din=data_q.
  - The memory commits the word on the negedge inside this cycle.
  - At posedge, decrement count and step cur_src/cur_dst by +1 (ascending) or -1 (descending).
  - If count reaches 0, go to DONE; else go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T0. The first READ is cycle T0+1, and done is high in cycle T0+2*len+1. For len=0, done is high in cycle T0+1.
- Address arithmetic is 32-bit unsigned with no wrap. The range check guarantees addresses stay within [0, 2^AW-1].
- In IDLE and DONE: mem_ren = mem_wen = 0, and mem_addr holds its last value.
- src == dst is a legal full copy (data is unchanged).

Optional Feature:
- Macro: MEMMOV_FILL_EN.
- When defined:
  - Adds input fill (1 bit, sampled with start) and input pattern (32 bits).
  - With fill=1: src is ignored, the READ state is skipped, and each WRITE stores pattern. Direction is always ascending, latency is T0+len+1, and the range check applies to dst only.
- When undefined: those ports do not exist and the block behaves exactly as above.

Test Plan:
- Preload mem[0..3] = 11,22,33,44. Start src=0, dst=100, len=4 -> mem[100..103] = 11,22,33,44; done high 9 cycles after start; ren&wen never both 1.
- Overlap forward: mem[10..13] = 1,2,3,4. Start src=10, dst=12, len=4 -> mem[12..15] = 1,2,3,4; addresses issued descending (13,15,12,14,...).
- Overlap backward: mem[12..15] = 1,2,3,4. Start src=12, dst=10, len=4 -> mem[10..13] = 1,2,3,4; addresses ascending.
- Start with len=0 -> done the next cycle, no ren/wen. Start src=1020, len=8 -> err pulse, no access, busy stays 0.
- Assert reset after 3 words of an 8-word copy -> next cycle all outputs 0, state IDLE; only the first 3 destination words changed.
- With MEMMOV_FILL_EN: fill=1, pattern=32'hDEADBEEF, dst=200, len=3 -> mem[200..202] = DEADBEEF, no ren asserted, done at T0+4.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if: request/status handshake plus the word-addressed data
// memory port of the block mover. The fill/pattern inputs exist only when
// MEMMOV_FILL_EN is defined.
interface mem_block_mover_if #(
    parameter int LW = 11
);
    logic          start;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_ren;
    logic          mem_wen;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
`ifdef MEMMOV_FILL_EN
    logic          fill;
    logic [31:0]   pattern;

    modport master (
        input  start, src, dst, len, fill, pattern, mem_dout,
        output busy, done, err, mem_ren, mem_wen, mem_addr, mem_din
    );
    modport slave (
        output start, src, dst, len, fill, pattern, mem_dout,
        input  busy, done, err, mem_ren, mem_wen, mem_addr, mem_din
    );
`else
    modport master (
        input  start, src, dst, len, mem_dout,
        output busy, done, err, mem_ren, mem_wen, mem_addr, mem_din
    );
    modport slave (
        output start, src, dst, len, mem_dout,
        input  busy, done, err, mem_ren, mem_wen, mem_addr, mem_din
    );
`endif
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: software-triggered memmove engine on the data memory port.
// Each word costs one READ cycle and one WRITE cycle; overlapping ranges with
// dst above src are copied top-down so source words are read before being
// overwritten. Optional fill mode (macro MEMMOV_FILL_EN) writes a constant
// pattern to the destination with no reads.
//
// state | meaning
// IDLE  | waiting for start; range check; err pulse on rejection
// READ  | mem_ren with cur_src, capture mem_dout into data_q
// WRITE | mem_wen with cur_dst/data_q, step pointers, count down
// DONE  | one-cycle done pulse, back to IDLE
module mem_block_mover #(
    parameter int AW = 10,
    parameter int LW = 11
) (
    input  logic              clock,
    input  logic              reset,
    mem_block_mover_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] count;
    logic [31:0]   cur_src;
    logic [31:0]   cur_dst;
    logic [31:0]   data_q;
    logic [31:0]   addr_hold;
    logic [31:0]   addr_now;
    logic          desc;
    logic          err_q;
    logic          fill_q;

    logic [32:0]   len_ext;
    logic [32:0]   src_end;
    logic [32:0]   dst_end;
    logic          len_zero;
    logic          range_bad;
    logic          go_desc;
    logic          start_fill;

    // Request decode: last-word addresses, range check and copy direction.
    // 33-bit sums so an out-of-range request can never wrap back into range.
    always_comb begin
        len_ext    = {{(33-LW){1'b0}}, bus.len};
        src_end    = {1'b0, bus.src} + len_ext - 33'd1;
        dst_end    = {1'b0, bus.dst} + len_ext - 33'd1;
        len_zero   = (bus.len == '0);
`ifdef MEMMOV_FILL_EN
        start_fill = bus.fill;
`else
        start_fill = 1'b0;
`endif
        range_bad  = !len_zero &&
                     ((!start_fill && (src_end[32:AW] != '0)) || (dst_end[32:AW] != '0));
        go_desc    = !start_fill &&
                     ({1'b0, bus.dst} > {1'b0, bus.src}) &&
                     ({1'b0, bus.dst} < ({1'b0, bus.src} + len_ext));
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && !range_bad) begin
                    if (len_zero)        state_nxt = DONE;
                    else if (start_fill) state_nxt = WRITE;
                    else                 state_nxt = READ;
                end
            end
            READ:  state_nxt = WRITE;
            WRITE: begin
                if (count == LW'(1)) state_nxt = DONE;
                else if (fill_q)     state_nxt = WRITE;
                else                 state_nxt = READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory address mux; outside READ/WRITE the last issued address is held.
    always_comb begin
        addr_now = addr_hold;
        if (state == READ)       addr_now = cur_src;
        else if (state == WRITE) addr_now = cur_dst;
    end

    assign bus.mem_ren  = (state == READ);
    assign bus.mem_wen  = (state == WRITE);
    assign bus.mem_addr = addr_now;
    assign bus.mem_din  = data_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.err      = err_q;

    // State register and datapath: request latch, read capture, pointer stepping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            data_q    <= '0;
            addr_hold <= '0;
            desc      <= 1'b0;
            err_q     <= 1'b0;
            fill_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            if ((state == READ) || (state == WRITE)) addr_hold <= addr_now;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (range_bad) begin
                            err_q <= 1'b1;
                        end else if (!len_zero) begin
                            count  <= bus.len;
                            desc   <= go_desc;
                            fill_q <= start_fill;
                            if (go_desc) begin
                                cur_src <= src_end[31:0];
                                cur_dst <= dst_end[31:0];
                            end else begin
                                cur_src <= bus.src;
                                cur_dst <= bus.dst;
                            end
`ifdef MEMMOV_FILL_EN
                            if (bus.fill) data_q <= bus.pattern;
`endif
                        end
                    end
                end
                READ: data_q <= bus.mem_dout;
                WRITE: begin
                    count <= count - LW'(1);
                    // skip the final step so pointers never leave the valid range
                    if (count != LW'(1)) begin
                        cur_src <= desc ? (cur_src - 32'd1) : (cur_src + 32'd1);
                        cur_dst <= desc ? (cur_dst - 32'd1) : (cur_dst + 32'd1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: table of copy requests checked against a memory model;
// expected read addresses and write {addr,data} pairs are queued when a
// request is issued and popped as the DUT drives the memory port.
module tb_mem_block_mover;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_block_mover_if #(.LW(11)) bus ();
    mem_block_mover #(.AW(10), .LW(11)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] orig    [1024];

    assign bus.mem_dout = (bus.mem_ren && !bus.mem_wen) ? mem[bus.mem_addr[9:0]] : 32'h0;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [10:0] len;
        logic        fill;
        logic [31:0] pattern;
        logic        exp_err;
        logic [31:0] exp_lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];

    int checks, failures;
    int cyc, conflicts, done_cnt, done_at, err_cnt, err_at, busy_c1, busy_cnt;
    int ren_cnt, wen_cnt, extra_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] s, input logic [31:0] d, input logic [10:0] l,
                           input logic f, input logic [31:0] p, input logic e, input int lat);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.fill = f; v.pattern = p;
        v.exp_err = e; v.exp_lat = 32'(lat);
        vecs.push_back(v);
    endtask

    task automatic clear_obs();
        exp_rd.delete(); exp_wr.delete();
        cyc = 0; conflicts = 0; done_cnt = 0; done_at = -1; err_cnt = 0; err_at = -1;
        busy_c1 = 0; busy_cnt = 0; ren_cnt = 0; wen_cnt = 0; extra_acc = 0;
        for (int i = 0; i < 1024; i++) orig[i] = mem[i];
    endtask

    // called at each negedge: scoreboard pops and the memory write
    task automatic observe();
        logic [31:0] ea;
        logic [63:0] ew;
        cyc++;
        if (bus.mem_ren && bus.mem_wen) conflicts++;
        if (bus.mem_ren) begin
            ren_cnt++;
            if (exp_rd.size() == 0) extra_acc++;
            else begin
                ea = exp_rd.pop_front();
                check($sformatf("rd_addr_c%0d", cyc), bus.mem_addr, ea);
            end
        end
        if (bus.mem_wen) begin
            wen_cnt++;
            if (exp_wr.size() == 0) extra_acc++;
            else begin
                ew = exp_wr.pop_front();
                check($sformatf("wr_addr_c%0d", cyc), bus.mem_addr, ew[63:32]);
                check($sformatf("wr_data_c%0d", cyc), bus.mem_din, ew[31:0]);
            end
            if (bus.mem_addr < 32'd1024) mem[bus.mem_addr[9:0]] = bus.mem_din;
        end
        if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
        end
        if (bus.err) begin
            err_cnt++;
            err_at = cyc;
        end
        if (cyc == 1) busy_c1 = int'(bus.busy);
        if (bus.busy) busy_cnt++;
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic drive_req(input logic [31:0] s, input logic [31:0] d, input logic [10:0] l,
                             input logic f, input logic [31:0] p);
        bus.src = s; bus.dst = d; bus.len = l;
`ifdef MEMMOV_FILL_EN
        bus.fill = f; bus.pattern = p;
`else
        if (f) $display("note: fill request issued without fill support");
        if (p != 32'h0) begin end
`endif
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic d;
        int   n_cyc;
        clear_obs();
        if (!v.exp_err) begin
            d = !v.fill && (v.dst > v.src) && (v.dst < v.src + 32'(v.len));
            for (int k = 0; k < int'(v.len); k++) begin
                int i;
                i = d ? int'(v.len) - 1 - k : k;
                if (v.fill) begin
                    exp_wr.push_back({v.dst + 32'(i), v.pattern});
                    ref_mem[int'(v.dst) + i] = v.pattern;
                end else begin
                    exp_rd.push_back(v.src + 32'(i));
                    exp_wr.push_back({v.dst + 32'(i), orig[int'(v.src) + i]});
                    ref_mem[int'(v.dst) + i] = orig[int'(v.src) + i];
                end
            end
        end
        drive_req(v.src, v.dst, v.len, v.fill, v.pattern);
        n_cyc = v.exp_err ? 4 : int'(v.exp_lat) + 3;
        repeat (n_cyc) begin
            @(negedge clock);
            observe();
        end
        @(posedge clock); #1;
        check($sformatf("v%0d_err_count", idx), err_cnt, v.exp_err ? 1 : 0);
        if (v.exp_err) check($sformatf("v%0d_err_cycle", idx), err_at, 1);
        check($sformatf("v%0d_done_count", idx), done_cnt, v.exp_err ? 0 : 1);
        if (!v.exp_err) check($sformatf("v%0d_done_cycle", idx), done_at, v.exp_lat);
        check($sformatf("v%0d_busy_c1", idx), busy_c1, v.exp_err ? 0 : 1);
        check($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.exp_err ? 0 : v.exp_lat);
        check($sformatf("v%0d_ren_wen_both", idx), conflicts, 0);
        check($sformatf("v%0d_rd_left", idx), exp_rd.size(), 0);
        check($sformatf("v%0d_wr_left", idx), exp_wr.size(), 0);
        check($sformatf("v%0d_extra_acc", idx), extra_acc, 0);
        check($sformatf("v%0d_mem_diff", idx), mem_diff(), 0);
    endtask

    // reset lands during the READ of word 4 of an 8-word copy
    task automatic reset_test();
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            ref_mem[400 + i] = orig[300 + i];
            exp_wr.push_back({32'(400 + i), orig[300 + i]});
        end
        for (int i = 0; i < 4; i++) exp_rd.push_back(32'(300 + i));
        drive_req(32'd300, 32'd400, 11'd8, 1'b0, 32'h0);
        for (int c = 0; c < 20 && wen_cnt < 3; c++) begin
            @(negedge clock);
            observe();
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        observe();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_err", bus.err, 0);
        check("rst_mid_ren", bus.mem_ren, 0);
        check("rst_mid_wen", bus.mem_wen, 0);
        check("rst_mid_addr", bus.mem_addr, 0);
        check("rst_mid_din", bus.mem_din, 0);
        repeat (4) begin
            @(negedge clock);
            observe();
        end
        @(posedge clock); #1;
        check("rst_mid_writes", wen_cnt, 3);
        check("rst_mid_reads", ren_cnt, 4);
        check("rst_mid_done_count", done_cnt, 0);
        check("rst_mid_rd_left", exp_rd.size(), 0);
        check("rst_mid_wr_left", exp_wr.size(), 0);
        check("rst_mid_extra_acc", extra_acc, 0);
        check("rst_mid_mem_diff", mem_diff(), 0);
    endtask

    initial begin
        vec_t v;
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
`ifdef MEMMOV_FILL_EN
        bus.fill = 1'b0; bus.pattern = '0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
        mem[10] = 32'd1; mem[11] = 32'd2; mem[12] = 32'd3; mem[13] = 32'd4;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_ren", bus.mem_ren, 0);
        check("reset_wen", bus.mem_wen, 0);
        check("reset_addr", bus.mem_addr, 0);
        check("reset_din", bus.mem_din, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        //      src            dst        len       fill  pattern        err   latency
        add_vec(32'd0,         32'd100,   11'd4,    1'b0, 32'h0,         1'b0, 9);
        add_vec(32'd10,        32'd12,    11'd4,    1'b0, 32'h0,         1'b0, 9);
        add_vec(32'd12,        32'd10,    11'd4,    1'b0, 32'h0,         1'b0, 9);
        add_vec(32'd5,         32'd5,     11'd0,    1'b0, 32'h0,         1'b0, 1);
        add_vec(32'd1020,      32'd0,     11'd8,    1'b0, 32'h0,         1'b1, 0);
        add_vec(32'd50,        32'd50,    11'd3,    1'b0, 32'h0,         1'b0, 7);
        add_vec(32'd0,         32'd1016,  11'd8,    1'b0, 32'h0,         1'b0, 17);
        add_vec(32'd0,         32'd1017,  11'd8,    1'b0, 32'h0,         1'b1, 0);
        add_vec(32'd1023,      32'd7,     11'd1,    1'b0, 32'h0,         1'b0, 3);
        add_vec(32'h0001_0000, 32'd0,     11'd1,    1'b0, 32'h0,         1'b1, 0);
        add_vec(32'd2000,      32'd0,     11'd0,    1'b0, 32'h0,         1'b0, 1);
        add_vec(32'd500,       32'd503,   11'd10,   1'b0, 32'h0,         1'b0, 21);
        add_vec(32'd0,         32'd0,     11'd1024, 1'b0, 32'h0,         1'b0, 2049);
`ifdef MEMMOV_FILL_EN
        add_vec(32'hFFFF_0000, 32'd200,   11'd3,    1'b1, 32'hDEADBEEF,  1'b0, 4);
        add_vec(32'd0,         32'd1022,  11'd3,    1'b1, 32'h12345678,  1'b1, 0);
`endif

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            run_vec(n, v);
        end

        reset_test();

        v.src = 32'd300; v.dst = 32'd400; v.len = 11'd8; v.fill = 1'b0; v.pattern = 32'h0;
        v.exp_err = 1'b0; v.exp_lat = 32'd17;
        run_vec(99, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
